multi_nibble_adder_ctrl: RTL and testbench

- Sequencer that adds two WIDTH-bit operands with one shared four_bit_adder_s slice, one nibble per clock, least significant nibble first.
- Registers the carry between nibbles and assembles the full result.
- Uses a start/ready/done handshake so the slice is reused instead of replicated.
- Sits between operand-producing logic and any consumer of wide sums.

---
 rtl/multi_nibble_adder_ctrl_if.sv | 34 +++
 rtl/multi_nibble_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_multi_nibble_adder_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_nibble_adder_ctrl_if.sv
// Handshake and operand/result bundle for multi_nibble_adder_ctrl.
// The sub signal exists only when MULTI_NIBBLE_ADDER_SUB_EN is defined.
interface multi_nibble_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             input_carry;
`ifdef MULTI_NIBBLE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             output_carry;

  modport master (
    output start, a, b, input_carry,
`ifdef MULTI_NIBBLE_ADDER_SUB_EN
    output sub,
`endif
    input  ready, busy, done, sum, output_carry
  );

  modport slave (
    input  start, a, b, input_carry,
`ifdef MULTI_NIBBLE_ADDER_SUB_EN
    input  sub,
`endif
    output ready, busy, done, sum, output_carry
  );
endinterface

// File: rtl/multi_nibble_adder_ctrl.sv
// Wide adder built from one shared 4-bit slice, one nibble per clock, LSB nibble first.
// Optional subtract mode: define MULTI_NIBBLE_ADDER_SUB_EN.
module four_bit_adder_s (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
endmodule

module multi_nibble_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multi_nibble_adder_ctrl_if.slave  bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("multi_nibble_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_ocarry;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_cap_b;
  logic               w_cap_cin;
  logic [3:0]         w_slice_a;
  logic [3:0]         w_slice_b;
  logic [3:0]         w_slice_sum;
  logic               w_slice_cout;

`ifdef MULTI_NIBBLE_ADDER_SUB_EN
  // Subtract as a + ~b + 1; input_carry is ignored in that mode.
  assign w_cap_b   = bus.sub ? ~bus.b : bus.b;
  assign w_cap_cin = bus.sub ? 1'b1 : bus.input_carry;
`else
  assign w_cap_b   = bus.b;
  assign w_cap_cin = bus.input_carry;
`endif

  assign w_accept  = (r_state == ST_IDLE) && bus.start;
  assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_slice_a = r_a[{r_idx, 2'b00} +: 4];
  assign w_slice_b = r_b[{r_idx, 2'b00} +: 4];

  four_bit_adder_s u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture and nibble-serial accumulation of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_carry  <= 1'b0;
      r_sum    <= {WIDTH{1'b0}};
      r_ocarry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_cap_b;
            r_carry <= w_cap_cin;
            r_idx   <= {IDX_W{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
          end
        end
        ST_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
          r_carry                    <= w_slice_cout;
          r_idx                      <= r_idx + IDX_W'(1);
          if (w_last) r_ocarry <= w_slice_cout;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready        = r_ready;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.sum          = r_sum;
  assign bus.output_carry = r_ocarry;
endmodule

// File: tb/tb_multi_nibble_adder_ctrl.sv
// Self-checking bench: a WIDTH=16 and a WIDTH=4 instance checked against an arithmetic model.
module tb_multi_nibble_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  multi_nibble_adder_ctrl_if #(.WIDTH(16)) ifc16 ();
  multi_nibble_adder_ctrl_if #(.WIDTH(4))  ifc4 ();

  multi_nibble_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16));
  multi_nibble_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4));

  always #5 clk = ~clk;

  // Returns {carry, sum} of a + b + cin (or a - b) truncated to w bits.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] s;
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    s = 64'(a & mask) + 64'(sub ? (~b & mask) : (b & mask)) + 64'(sub ? 1'b1 : cin);
    return {s[w], s[31:0] & mask};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input string tag);
    logic [32:0] exp;
    int nbusy;
    int ndone;
    exp = ref_add(16, {16'd0, a}, {16'd0, b}, cin, sub);
    ifc16.a = a;
    ifc16.b = b;
    ifc16.input_carry = cin;
`ifdef MULTI_NIBBLE_ADDER_SUB_EN
    ifc16.sub = sub;
`endif
    ifc16.start = 1'b1;
    check({tag, "_ready_pre"}, 32'(ifc16.ready), 32'd1);
    tick();
    ifc16.start = 1'b0;
    ifc16.a = ~a;
    ifc16.b = ~b;
    ifc16.input_carry = ~cin;
    check({tag, "_ready_run"}, 32'(ifc16.ready), 32'd0);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc16.done) begin
        ndone = 1;
        break;
      end
      if (ifc16.busy) nbusy++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
    check({tag, "_done_seen"}, 32'(ndone), 32'd1);
    check({tag, "_sum"}, 32'(ifc16.sum), {16'd0, exp[15:0]});
    check({tag, "_cout"}, 32'(ifc16.output_carry), {31'd0, exp[32]});
    tick();
    check({tag, "_done_pulse"}, 32'(ifc16.done), 32'd0);
    check({tag, "_ready_post"}, 32'(ifc16.ready), 32'd1);
    repeat (2) tick();
    check({tag, "_sum_hold"}, 32'(ifc16.sum), {16'd0, exp[15:0]});
    check({tag, "_cout_hold"}, 32'(ifc16.output_carry), {31'd0, exp[32]});
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input string tag);
    logic [32:0] exp;
    int nbusy;
    int ndone;
    exp = ref_add(4, {28'd0, a}, {28'd0, b}, cin, 1'b0);
    ifc4.a = a;
    ifc4.b = b;
    ifc4.input_carry = cin;
    ifc4.start = 1'b1;
    tick();
    ifc4.start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc4.done) begin
        ndone = 1;
        break;
      end
      if (ifc4.busy) nbusy++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd1);
    check({tag, "_done_seen"}, 32'(ndone), 32'd1);
    check({tag, "_sum"}, 32'(ifc4.sum), {28'd0, exp[3:0]});
    check({tag, "_cout"}, 32'(ifc4.output_carry), {31'd0, exp[32]});
    tick();
    check({tag, "_ready_post"}, 32'(ifc4.ready), 32'd1);
  endtask

  initial begin
    int ndone;
    logic [32:0] exp;
    rst_n = 1'b0;
    ifc16.start = 1'b0; ifc16.a = 16'd0; ifc16.b = 16'd0; ifc16.input_carry = 1'b0;
    ifc4.start  = 1'b0; ifc4.a  = 4'd0;  ifc4.b  = 4'd0;  ifc4.input_carry  = 1'b0;
`ifdef MULTI_NIBBLE_ADDER_SUB_EN
    ifc16.sub = 1'b0;
    ifc4.sub  = 1'b0;
`endif
    tick();
    check("rst_ready", 32'(ifc16.ready), 32'd1);
    check("rst_busy", 32'(ifc16.busy), 32'd0);
    check("rst_done", 32'(ifc16.done), 32'd0);
    check("rst_sum", 32'(ifc16.sum), 32'd0);
    check("rst_cout", 32'(ifc16.output_carry), 32'd0);
    check("rst_ready4", 32'(ifc4.ready), 32'd1);
    rst_n = 1'b1;
    tick();

    op16(16'h00FF, 16'h0001, 1'b0, 1'b0, "d_00ff");
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "d_ffff");
    op16(16'h1234, 16'h4321, 1'b1, 1'b0, "d_cin");

    // Requests raised during RUN and DONE must not be taken until ready returns.
    ifc16.a = 16'h1111; ifc16.b = 16'h2222; ifc16.input_carry = 1'b0; ifc16.start = 1'b1;
    tick();
    ifc16.a = 16'hFFFF; ifc16.b = 16'hFFFF;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (ifc16.done) begin
        ndone++;
        check("busy_start_sum", 32'(ifc16.sum), 32'h3333);
      end
      if (ifc16.ready) break;
      tick();
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_hold", 32'(ifc16.sum), 32'h3333);
    tick();
    ifc16.start = 1'b0;
    check("second_accept_busy", 32'(ifc16.busy), 32'd1);
    exp = ref_add(16, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (ifc16.done) begin
        ndone = 1;
        break;
      end
      tick();
    end
    check("second_done", 32'(ndone), 32'd1);
    check("second_sum", 32'(ifc16.sum), {16'd0, exp[15:0]});
    check("second_cout", 32'(ifc16.output_carry), {31'd0, exp[32]});
    tick();

    // Asynchronous reset while idx=2, asserted between clock edges.
    ifc16.a = 16'hABCD; ifc16.b = 16'h1357; ifc16.start = 1'b1;
    tick();
    ifc16.start = 1'b0;
    repeat (2) tick();
    check("mid_busy_before", 32'(ifc16.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ifc16.ready), 32'd1);
    check("mid_rst_busy", 32'(ifc16.busy), 32'd0);
    check("mid_rst_done", 32'(ifc16.done), 32'd0);
    check("mid_rst_sum", 32'(ifc16.sum), 32'd0);
    check("mid_rst_cout", 32'(ifc16.output_carry), 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (ifc16.done) ndone++;
      tick();
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    op16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "after_rst");

    for (int k = 0; k < 12; k++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0, "rand16");
    end

`ifdef MULTI_NIBBLE_ADDER_SUB_EN
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
    op16(16'h0007, 16'h0005, 1'b1, 1'b1, "sub_noborrow");
    for (int k = 0; k < 6; k++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b1, "rand_sub");
    end
    op16(16'h0007, 16'h0005, 1'b1, 1'b0, "add_after_sub");
`endif

    op4(4'hB, 4'hD, 1'b0, "w4_bd");
    for (int k = 0; k < 8; k++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom_range(1, 0)), "rand4");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
